// File: rtl/tff_seq_ctrl.sv
// Sequencing controller for a W-bit T-flip-flop bank: LOAD/TOGGLE/COUNT commands over valid/ready.
// Optional autoreload of the count start value is enabled by defining TFF_SEQ_CTRL_AUTORELOAD_EN.
module tff_seq_ctrl #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_data,
   input  logic         pause,
   input  logic         stop,
   output logic [W-1:0] t,
   output logic [W-1:0] q,
   output logic         busy,
   output logic         done,
   output logic         wrap
);

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_UP     = 2'b01;
   localparam logic [1:0] OP_DOWN   = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_RUN   = 2'd2
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
      , S_RELOAD = 2'd3
`endif
   } state_t;

   state_t       r_state;
   state_t       w_nextState;
   logic [W-1:0] r_q;
   logic [1:0]   r_op;
   logic [W-1:0] r_data;
   logic         r_done;
   logic         w_done;
   logic         w_accept;
   logic [W-1:0] w_t;
   logic [W-1:0] w_qNext;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down).
   function automatic logic [W-1:0] upMask(input logic [W-1:0] v);
      logic [W-1:0] m;
      logic         acc;
      m   = '0;
      acc = 1'b1;
      for (int i = 0; i < W; i++) begin
         m[i] = acc;
         acc  = acc & v[i];
      end
      return m;
   endfunction

   function automatic logic [W-1:0] downMask(input logic [W-1:0] v);
      logic [W-1:0] m;
      logic         acc;
      m   = '0;
      acc = 1'b1;
      for (int i = 0; i < W; i++) begin
         m[i] = acc;
         acc  = acc & ~v[i];
      end
      return m;
   endfunction

   assign w_accept = cmd_valid && (r_state == S_IDLE);

`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
   logic [W-1:0] r_start;
   logic         r_wrap;
   logic         w_wrap;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_start <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= w_wrap;
         if (w_accept && (cmd_op == OP_UP || cmd_op == OP_DOWN)) begin
            r_start <= r_q;
         end
      end
   end

   assign wrap = r_wrap;
`else
   assign wrap = 1'b0;
`endif

   always_comb begin
      w_t = '0;
      case (r_state)
         S_APPLY: w_t = (r_op == OP_LOAD) ? (r_q ^ r_data) : r_data;
         S_RUN: begin
            if (!stop && !pause) begin
               w_t = (r_op == OP_DOWN) ? downMask(r_q) : upMask(r_q);
            end
         end
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
         S_RELOAD: begin
            if (!stop) begin
               w_t = r_q ^ r_start;
            end
         end
`endif
         default: w_t = '0;
      endcase
   end

   assign w_qNext = r_q ^ w_t;

   // Limit compare uses the value the bank will hold after this edge.
   always_comb begin
      w_nextState = r_state;
      w_done      = 1'b0;
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
      w_wrap      = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_nextState = (cmd_op == OP_LOAD || cmd_op == OP_TOGGLE) ? S_APPLY : S_RUN;
            end
         end
         S_APPLY: begin
            w_done      = 1'b1;
            w_nextState = S_IDLE;
         end
         S_RUN: begin
            if (stop) begin
               w_done      = 1'b1;
               w_nextState = S_IDLE;
            end else if (!pause && (w_qNext == r_data)) begin
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
               w_wrap      = 1'b1;
               w_nextState = S_RELOAD;
`else
               w_done      = 1'b1;
               w_nextState = S_IDLE;
`endif
            end
         end
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
         S_RELOAD: begin
            if (stop) begin
               w_done      = 1'b1;
               w_nextState = S_IDLE;
            end else begin
               w_nextState = S_RUN;
            end
         end
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_op    <= OP_LOAD;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_q     <= w_qNext;
         r_done  <= w_done;
         if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
         end
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign t         = w_t;
   assign q         = r_q;
   assign done      = r_done;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Scoreboard bench for tff_seq_ctrl: commands push the expected completion value, a monitor checks done/wrap.
// Autoreload checks are built only when TFF_SEQ_CTRL_AUTORELOAD_EN is defined.
module tb_tff_seq_ctrl;

   localparam int W = 4;
   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_UP     = 2'b01;
   localparam logic [1:0] OP_DOWN   = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   logic         clk;
   logic         clrn;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic         pause;
   logic         stop;
   logic [W-1:0] t;
   logic [W-1:0] q;
   logic         busy;
   logic         done;
   logic         wrap;

   int nChecks = 0;
   int nPass   = 0;
   logic [W-1:0] doneQ[$];
   logic [W-1:0] wrapQ[$];

   tff_seq_ctrl #(.W(W)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .pause     (pause),
      .stop      (stop),
      .t         (t),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the command until accepted, then returns just after the acceptance edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data, input logic [W-1:0] expQ);
      int n;
      n         = 0;
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      checkOutput("ready_wait", int'(cmd_ready), 1);
      doneQ.push_back(expQ);
      tick();
      cmd_valid = 1'b0;
      checkOutput("busy_after_accept", int'(busy), 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (clrn) begin
            if (done) begin
               checkOutput("done_pending", int'(doneQ.size() > 0), 1);
               checkOutput("done_wrap_excl", int'(wrap), 0);
               if (doneQ.size() > 0) checkOutput("done_q", int'(q), int'(doneQ.pop_front()));
            end
            if (wrap) begin
               checkOutput("wrap_pending", int'(wrapQ.size() > 0), 1);
               if (wrapQ.size() > 0) checkOutput("wrap_q", int'(q), int'(wrapQ.pop_front()));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clrn      = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_data  = '0;
      pause     = 1'b0;
      stop      = 1'b0;
      #2 clrn = 1'b0;
      #1;
      checkOutput("rst_q", int'(q), 0);
      checkOutput("rst_ready", int'(cmd_ready), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_wrap", int'(wrap), 0);
      checkOutput("rst_t", int'(t), 0);
      #19 clrn = 1'b1;
      tick();
      checkOutput("release_done", int'(done), 0);
      checkOutput("release_wrap", int'(wrap), 0);

      // LOAD A then TOGGLE 3 at the earliest legal edge.
      applyStimulus(OP_LOAD, 4'hA, 4'hA);
      checkOutput("t_load", int'(t), 'hA);
      checkOutput("ready_in_apply", int'(cmd_ready), 0);
      tick();
      checkOutput("q_load", int'(q), 'hA);
      checkOutput("done_load", int'(done), 1);
      checkOutput("ready_after_load", int'(cmd_ready), 1);
      applyStimulus(OP_TOGGLE, 4'h3, 4'h9);
      checkOutput("t_toggle", int'(t), 3);
      tick();
      checkOutput("q_toggle", int'(q), 9);
      checkOutput("done_toggle", int'(done), 1);

      // Count up 3 -> 6 with two paused cycles.
      applyStimulus(OP_LOAD, 4'h3, 4'h3);
      tick();
      applyStimulus(OP_UP, 4'h6, 4'h6);
      checkOutput("t_up3", int'(t), 'b0111);
      tick();
      checkOutput("q_up4", int'(q), 4);
      pause = 1'b1;
      #1;
      checkOutput("t_pause1", int'(t), 0);
      tick();
      checkOutput("q_pause1", int'(q), 4);
      checkOutput("t_pause2", int'(t), 0);
      tick();
      checkOutput("q_pause2", int'(q), 4);
      pause = 1'b0;
      tick();
      checkOutput("q_up5", int'(q), 5);
      checkOutput("done_up_early", int'(done), 0);
      tick();
      checkOutput("q_up6", int'(q), 6);
      checkOutput("done_up", int'(done), 1);

      // Count down 1 -> 14 through wrap.
      applyStimulus(OP_LOAD, 4'h1, 4'h1);
      tick();
      applyStimulus(OP_DOWN, 4'hE, 4'hE);
      checkOutput("t_dn1", int'(t), 1);
      tick();
      checkOutput("q_dn0", int'(q), 0);
      checkOutput("t_dn0", int'(t), 'hF);
      tick();
      checkOutput("q_dn15", int'(q), 15);
      tick();
      checkOutput("q_dn14", int'(q), 14);
      checkOutput("done_dn", int'(done), 1);

      // Start equal to limit: full 16-step lap.
      applyStimulus(OP_LOAD, 4'h7, 4'h7);
      tick();
      applyStimulus(OP_UP, 4'h7, 4'h7);
      for (int i = 1; i <= 16; i++) begin
         tick();
         checkOutput($sformatf("q_lap%0d", i), int'(q), (7 + i) % 16);
         checkOutput($sformatf("done_lap%0d", i), int'(done), (i == 16) ? 1 : 0);
      end

      // Stop with pause and a held LOAD while busy.
      applyStimulus(OP_LOAD, 4'h0, 4'h0);
      tick();
      applyStimulus(OP_UP, 4'hF, 4'h4);
      repeat (4) tick();
      checkOutput("q_before_stop", int'(q), 4);
      stop      = 1'b1;
      pause     = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = 4'h2;
      cmd_valid = 1'b1;
      #1;
      checkOutput("t_stop", int'(t), 0);
      checkOutput("ready_stop", int'(cmd_ready), 0);
      tick();
      checkOutput("q_stop", int'(q), 4);
      checkOutput("done_stop", int'(done), 1);
      checkOutput("ready_after_stop", int'(cmd_ready), 1);
      stop  = 1'b0;
      pause = 1'b0;
      doneQ.push_back(4'h2);
      tick();
      cmd_valid = 1'b0;
      checkOutput("busy_held_load", int'(busy), 1);
      checkOutput("q_held_load_pending", int'(q), 4);
      tick();
      checkOutput("q_held_load", int'(q), 2);

`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
      // Autoreload 2 -> 4, reload, again, then stop from RELOAD.
      applyStimulus(OP_LOAD, 4'h2, 4'h2);
      tick();
      wrapQ.push_back(4'h4);
      wrapQ.push_back(4'h4);
      applyStimulus(OP_UP, 4'h4, 4'h4);
      tick();
      checkOutput("ar_q3a", int'(q), 3);
      tick();
      checkOutput("ar_q4a", int'(q), 4);
      checkOutput("ar_wrap_a", int'(wrap), 1);
      checkOutput("ar_nodone_a", int'(done), 0);
      checkOutput("ar_t_reload", int'(t), 6);
      tick();
      checkOutput("ar_q2", int'(q), 2);
      checkOutput("ar_wrap_low", int'(wrap), 0);
      tick();
      checkOutput("ar_q3b", int'(q), 3);
      tick();
      checkOutput("ar_q4b", int'(q), 4);
      checkOutput("ar_wrap_b", int'(wrap), 1);
      stop = 1'b1;
      #1;
      checkOutput("ar_t_stop", int'(t), 0);
      tick();
      stop = 1'b0;
      checkOutput("ar_q_stop", int'(q), 4);
      checkOutput("ar_done_stop", int'(done), 1);
      checkOutput("ar_wrap_stop", int'(wrap), 0);
`endif

      @(negedge clk);
      #1;
      checkOutput("sb_done_drained", doneQ.size(), 0);
      checkOutput("sb_wrap_drained", wrapQ.size(), 0);

      // Asynchronous reset in the middle of a count at q=5.
      tick();
      applyStimulus(OP_LOAD, 4'h0, 4'h0);
      tick();
      applyStimulus(OP_UP, 4'h9, 4'h9);
      repeat (5) tick();
      checkOutput("q_before_rst", int'(q), 5);
      checkOutput("t_before_rst", int'(t), 'b0011);
      #2 clrn = 1'b0;
      #1;
      doneQ.delete();
      checkOutput("mid_rst_q", int'(q), 0);
      checkOutput("mid_rst_ready", int'(cmd_ready), 1);
      checkOutput("mid_rst_busy", int'(busy), 0);
      checkOutput("mid_rst_done", int'(done), 0);
      checkOutput("mid_rst_t", int'(t), 0);
      #3 clrn = 1'b1;
      tick();
      checkOutput("post_rst_done", int'(done), 0);
      checkOutput("post_rst_busy", int'(busy), 0);
      checkOutput("post_rst_q", int'(q), 0);
      tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
